avalon_burst_slave_buf: RTL and testbench

// - Avalon-MM burst slave that terminates the wide host-side master bus and owns a word-addressed buffer RAM.
// - Host bursts write the buffer and read it back; the downstream curl core reads the same RAM through a side port.
// - Sits directly downstream of the Avalon master; only data transport, no hashing logic.

---
 rtl/avalon_burst_slave_buf.sv | 85 ++++++++
 tb/tb_avalon_burst_slave_buf.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/avalon_burst_slave_buf.sv
// avalon_burst_slave_buf: Avalon-MM burst slave over a byte-lane buffer RAM with a registered core read port
module avalon_burst_slave_buf #(
  parameter int DATA_W  = 1024,
  parameter int BE_W    = 128,
  parameter int DEPTH   = 64,
  parameter int BURST_W = 11,
  parameter int RD_LAT  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              address,
  input  logic [BE_W-1:0]          byteenable,
  input  logic                     chipselect,
  input  logic                     read,
  input  logic                     write,
  input  logic [DATA_W-1:0]        writedata,
  input  logic [BURST_W-1:0]       burstcount,
  input  logic                     beginbursttransfer,
  output logic [DATA_W-1:0]        readdata,
  output logic                     waitrequest,
  output logic                     readdatavalid,
  input  logic [$clog2(DEPTH)-1:0] core_rd_addr,
  output logic [DATA_W-1:0]        core_rd_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int BO = $clog2(BE_W);
  typedef enum logic [1:0] {IDLE, WR_BURST, RD_CMD_WAIT, RD_BURST} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] word, ptr, wa;
  logic [BURST_W-1:0] bc, beats_left;
  logic [7:0] lat_cnt;
  logic up, accept, wr_en, issue, last;
  logic unused_bits;
  assign unused_bits = ^{beginbursttransfer, address[31:BO+AW], address[BO-1:0]};
  assign word   = address[BO+:AW];
  assign bc     = (burstcount == '0) ? BURST_W'(1) : burstcount;
  assign accept = chipselect & (read | write) & ~waitrequest;
  assign last   = beats_left == BURST_W'(1);
  assign issue  = (state == RD_CMD_WAIT && lat_cnt == 8'd0) || state == RD_BURST;
  assign wr_en  = (state == IDLE && accept && write) || (state == WR_BURST && chipselect && write);
  assign wa     = (state == IDLE) ? word : ptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        state_nx = !accept ? IDLE : write ? ((bc > BURST_W'(1)) ? WR_BURST : IDLE) : RD_CMD_WAIT;
      WR_BURST:    state_nx = (chipselect && write && last) ? IDLE : WR_BURST;
      RD_CMD_WAIT: state_nx = (lat_cnt != 8'd0) ? RD_CMD_WAIT : last ? IDLE : RD_BURST;
      RD_BURST:    state_nx = last ? IDLE : RD_BURST;
      default:     state_nx = IDLE;
    endcase
  end
  // The last read beat is launched on the edge that returns the FSM to IDLE, so
  // waitrequest falls in the same cycle readdatavalid is last high.
  always_comb waitrequest = !up || state == RD_CMD_WAIT || state == RD_BURST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      up            <= 1'b0;
      ptr           <= '0;
      beats_left    <= '0;
      lat_cnt       <= '0;
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      up            <= 1'b1;
      readdatavalid <= issue;
      if (issue) readdata <= mem[ptr];
      if (state == IDLE && accept) begin
        ptr        <= write ? word + AW'(1) : word;
        beats_left <= write ? bc - BURST_W'(1) : bc;
        lat_cnt    <= 8'(RD_LAT - 1);
      end else if (wr_en || issue) begin
        ptr        <= ptr + AW'(1);
        beats_left <= beats_left - BURST_W'(1);
      end else if (state == RD_CMD_WAIT) lat_cnt <= lat_cnt - 8'd1;
    end
  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++)
      if (wr_en && byteenable[b]) mem[wa][8*b+:8] <= writedata[8*b+:8];
    core_rd_data <= mem[core_rd_addr];
  end
endmodule

// File: tb/tb_avalon_burst_slave_buf.sv
// tb_avalon_burst_slave_buf: directed bench for the Avalon burst slave buffer
module tb_avalon_burst_slave_buf;
  localparam int DATA_W = 1024, BE_W = 128, DEPTH = 64, BURST_W = 11, RD_LAT = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, chipselect, read, write, beginbursttransfer, waitrequest, readdatavalid;
  logic [31:0] address;
  logic [BE_W-1:0] byteenable;
  logic [DATA_W-1:0] writedata, readdata, core_rd_data;
  logic [BURST_W-1:0] burstcount;
  logic [5:0] core_rd_addr;
  int passes = 0, checks = 0, fails = 0;
  logic [DATA_W-1:0] dat [8];
  logic [DATA_W-1:0] a_w, e_w, d_w [4], w_w [3], pat;
  logic [DATA_W-1:0] t5_d [10];
  localparam logic [BE_W-1:0] ALL = '1;

  avalon_burst_slave_buf #(.DATA_W(DATA_W), .BE_W(BE_W), .DEPTH(DEPTH), .BURST_W(BURST_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .byteenable(byteenable), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .burstcount(burstcount),
    .beginbursttransfer(beginbursttransfer), .readdata(readdata), .waitrequest(waitrequest),
    .readdatavalid(readdatavalid), .core_rd_addr(core_rd_addr), .core_rd_data(core_rd_data));

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s got=%h exp=%h (low 128 bits)", tag, got[127:0], exp[127:0]);
    end
  endtask

  task automatic wr(input int word, input logic [BE_W-1:0] be, input int bc, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_wrq"}, waitrequest, 0);
      chipselect = 1; write = 1; address = 32'(word) << 7; byteenable = be;
      burstcount = BURST_W'(bc); writedata = dat[i];
    end
    @(negedge clk);
    chipselect = 0; write = 0;
  endtask

  task automatic rd(input int word, input int bc, input int n, input string tag);
    @(negedge clk);
    chk({tag, "_wrq_idle"}, waitrequest, 0);
    chipselect = 1; read = 1; address = 32'(word) << 7; burstcount = BURST_W'(bc);
    @(negedge clk);
    chipselect = 0; read = 0;
    for (int m = 0; m <= RD_LAT + n; m++) begin
      if (m > 0) @(negedge clk);
      chk($sformatf("%s_rdv%0d", tag, m), readdatavalid, (m >= RD_LAT && m < RD_LAT + n));
      if (m >= RD_LAT && m < RD_LAT + n) chk($sformatf("%s_data%0d", tag, m - RD_LAT), readdata, dat[m - RD_LAT]);
      chk($sformatf("%s_wrq%0d", tag, m), waitrequest, (m < RD_LAT + n - 1));
    end
  endtask

  initial begin
    rst_n = 0; chipselect = 0; read = 0; write = 0; beginbursttransfer = 0;
    address = '0; byteenable = '0; writedata = '0; burstcount = '0; core_rd_addr = '0;
    a_w = {32{32'hA5A5_0001}};
    e_w = {32{32'hE1E1_0007}};
    for (int i = 0; i < 4; i++) d_w[i] = {32{32'hD000_0000 + 32'(i)}};
    for (int i = 0; i < 3; i++) w_w[i] = {32{32'h7770_0000 + 32'(i)}};
    repeat (3) @(negedge clk);
    chk("rst_wrq", waitrequest, 1);
    chk("rst_rdv", readdatavalid, 0);
    chk("rst_rdata", readdata, 0);
    rst_n = 1;
    #1 chk("rel_wrq_before_edge", waitrequest, 1);
    @(negedge clk);
    chk("rel_wrq_after_edge", waitrequest, 0);
    // single write and single read of word 1
    dat[0] = a_w;
    wr(1, ALL, 1, 1, "t1w");
    rd(1, 1, 1, "t1r");
    // wrapping burst of 4 at word 62
    for (int i = 0; i < 4; i++) dat[i] = d_w[i];
    wr(62, ALL, 4, 4, "t2w");
    rd(62, 4, 4, "t2r");
    // partial byte write over zeros, core port old-then-new
    dat[0] = '0;
    wr(5, ALL, 1, 1, "t3z");
    pat = '0; pat[7:0] = 8'hFF;
    @(negedge clk);
    chipselect = 1; write = 1; address = 32'h280; byteenable = 128'h1; writedata = '1; burstcount = 1;
    core_rd_addr = 6'd5;
    @(negedge clk);
    chipselect = 0; write = 0;
    chk("t3_core_old", core_rd_data, 0);
    @(negedge clk);
    chk("t3_core_new", core_rd_data, pat);
    dat[0] = pat;
    rd(5, 1, 1, "t3r");
    // burst 3 with two idle cycles between beats 1 and 2
    @(negedge clk);
    chipselect = 1; write = 1; address = 32'(10) << 7; byteenable = ALL; burstcount = 3; writedata = w_w[0];
    @(negedge clk);
    writedata = w_w[1];
    @(negedge clk);
    write = 0;
    chk("t4_gap0_wrq", waitrequest, 0);
    @(negedge clk);
    chk("t4_gap1_wrq", waitrequest, 0);
    @(negedge clk);
    chk("t4_gap2_wrq", waitrequest, 0);
    write = 1; writedata = w_w[2];
    @(negedge clk);
    chipselect = 0; write = 0;
    for (int i = 0; i < 3; i++) dat[i] = w_w[i];
    rd(10, 3, 3, "t4r");
    // burstcount 0 behaves as 1
    dat[0] = e_w;
    wr(30, ALL, 0, 1, "t5w");
    rd(30, 0, 1, "t5r");
    // second read command held off by the first burst (2 beats at 62, then 3 at 10)
    for (int m = 0; m < 10; m++) t5_d[m] = '0;
    t5_d[2] = d_w[0]; t5_d[3] = d_w[1]; t5_d[6] = w_w[0]; t5_d[7] = w_w[1]; t5_d[8] = w_w[2];
    @(negedge clk);
    chipselect = 1; read = 1; address = 32'(62) << 7; burstcount = 2;
    @(negedge clk);
    address = 32'(10) << 7; burstcount = 3;
    for (int m = 0; m < 10; m++) begin
      if (m > 0) @(negedge clk);
      if (m == 4) begin chipselect = 0; read = 0; end
      chk($sformatf("t6_rdv%0d", m), readdatavalid, (m == 2 || m == 3 || (m >= 6 && m <= 8)));
      if (readdatavalid) chk($sformatf("t6_data%0d", m), readdata, t5_d[m]);
      chk($sformatf("t6_wrq%0d", m), waitrequest, !(m == 3 || m >= 8));
    end
    // reset during beat 2 of an 8-beat read
    @(negedge clk);
    chipselect = 1; read = 1; address = 32'h0; burstcount = 8;
    @(negedge clk);
    chipselect = 0; read = 0;
    repeat (2) @(negedge clk);
    chk("t7_beat0", readdata, d_w[2]);
    @(negedge clk);
    chk("t7_beat1", readdata, d_w[3]);
    @(negedge clk);
    chk("t7_beat2_rdv", readdatavalid, 1);
    rst_n = 0;
    #1;
    chk("t7_rst_rdv", readdatavalid, 0);
    chk("t7_rst_wrq", waitrequest, 1);
    chk("t7_rst_rdata", readdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("t7_rel_wrq", waitrequest, 0);
    chk("t7_rel_rdv", readdatavalid, 0);
    dat[0] = e_w;
    wr(20, ALL, 1, 1, "t7w");
    rd(20, 1, 1, "t7r");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
